mem_port_arbiter: RTL and testbench

Arbitrates the single shared memory port between the CPU's instruction-fetch stage (IF) and data-memory stage (DM) in the pipelined machine. Sits between the CPU pipeline and the 512x16 synchronous RAM. Issues at most one memory command per cycle and tracks the one outstanding read. Routes returned read data back to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter: shares one synchronous RAM port between the IF and DM
// pipeline stages, tracks the single outstanding read and routes its data.
// Optional IF fairness override: define MEM_ARB_FAIRNESS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int AW          = 9,
  parameter int DW          = 16,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] c_cmd_none  = 2'b00;
  localparam logic [1:0] c_cmd_read  = 2'b01;
  localparam logic [1:0] c_cmd_write = 2'b10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  owner_t        r_owner;
  logic [DW-1:0] r_if_hold;
  logic [DW-1:0] r_dm_hold;
  logic          w_if_gnt;
  logic          w_dm_gnt;
  logic          w_force_if;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int c_sw = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [c_sw-1:0] c_streak_max = c_sw'(MAX_DSTREAK);

  logic [c_sw-1:0] r_streak;

  assign w_force_if = if_req && dm_req && (r_streak == c_streak_max);

  // Counts only contested DM wins; any cycle without IF demand restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_streak <= '0;
    end else if (!if_req || w_if_gnt) begin
      r_streak <= '0;
    end else if (w_dm_gnt && (r_streak != c_streak_max)) begin
      r_streak <= r_streak + 1'b1;
    end
  end
`else
  logic w_unused_streak_cfg;

  assign w_force_if          = 1'b0;
  assign w_unused_streak_cfg = (MAX_DSTREAK != 0);
`endif

  // Grants are gated by reset_n so requests seen during reset have no effect.
  assign w_dm_gnt = reset_n && dm_req && !w_force_if;
  assign w_if_gnt = reset_n && if_req && (!dm_req || w_force_if);
  assign dm_gnt   = w_dm_gnt;
  assign if_gnt   = w_if_gnt;

  always_comb begin
    mem_cmd   = c_cmd_none;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_dm_gnt) begin
      mem_cmd   = dm_we ? c_cmd_write : c_cmd_read;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (w_if_gnt) begin
      mem_cmd   = c_cmd_read;
      mem_addr  = if_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= OWN_NONE;
    end else if (w_dm_gnt && !dm_we) begin
      r_owner <= OWN_DM;
    end else if (w_if_gnt) begin
      r_owner <= OWN_IF;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  assign if_rvalid = (r_owner == OWN_IF);
  assign dm_rvalid = (r_owner == OWN_DM);

  // Hold registers capture the returned word so rdata stays stable afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if_hold <= '0;
      r_dm_hold <= '0;
    end else begin
      if (if_rvalid) r_if_hold <= mem_rdata;
      if (dm_rvalid) r_dm_hold <= mem_rdata;
    end
  end

  assign if_rdata = if_rvalid ? mem_rdata : r_if_hold;
  assign dm_rdata = dm_rvalid ? mem_rdata : r_dm_hold;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter: drives mem_port_arbiter against a 512x16 RAM model and
// checks grants, commands and scoreboarded read returns.
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram     [512];
  logic [DW-1:0] exp_mem [512];

  always @(posedge clk) begin
    if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
    else if (mem_cmd == 2'b01) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int            due;
    bit            is_dm;
    logic [DW-1:0] data;
  } sb_t;

  sb_t sbq[$];
  sb_t e;
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: returns are checked when due, grants are recorded afterwards.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      n_tests++;
      if (e.is_dm) begin
        if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0 || dm_rdata !== e.data) begin
          n_fail++;
          $display("FAIL sb_dm_return cyc=%0d: dm_rvalid=%b if_rvalid=%b dm_rdata=%h, want 1 0 %h",
                   cyc, dm_rvalid, if_rvalid, dm_rdata, e.data);
        end
      end else begin
        if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0 || if_rdata !== e.data) begin
          n_fail++;
          $display("FAIL sb_if_return cyc=%0d: if_rvalid=%b dm_rvalid=%b if_rdata=%h, want 1 0 %h",
                   cyc, if_rvalid, dm_rvalid, if_rdata, e.data);
        end
      end
    end else if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_spurious_rvalid cyc=%0d: if_rvalid=%b dm_rvalid=%b, want 0 0",
               cyc, if_rvalid, dm_rvalid);
    end
    if (reset_n) begin
      if (dm_gnt === 1'b1) begin
        if (dm_we) exp_mem[dm_addr] = dm_wdata;
        else sbq.push_back('{due: cyc + 1, is_dm: 1'b1, data: exp_mem[dm_addr]});
      end
      if (if_gnt === 1'b1)
        sbq.push_back('{due: cyc + 1, is_dm: 1'b0, data: exp_mem[if_addr]});
    end
  end

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 9'd3, 1'b1, 1'b0, 9'd4, 16'h0);
    @(negedge clk);
    n_tests++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_cmd} !== 6'b0 ||
        if_rdata !== 16'h0 || dm_rdata !== 16'h0 || mem_addr !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b%b rv=%b%b cmd=%b addr=%h rdata=%h/%h, want all 0",
               if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_cmd, mem_addr, if_rdata, dm_rdata);
    end
    next_cycle();
    reset_n = 1'b1;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
    @(negedge clk);
    n_tests++;
    if (mem_cmd !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_idle: mem_cmd=%b, want 00", mem_cmd);
    end
  endtask

  task automatic test_if_read();
    next_cycle();
    drive(1'b1, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
    @(negedge clk);
    n_tests++;
    if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || mem_cmd !== 2'b01 || mem_addr !== 9'd0) begin
      n_fail++;
      $display("FAIL if_read_grant: if_gnt=%b dm_gnt=%b cmd=%b addr=%h, want 1 0 01 000",
               if_gnt, dm_gnt, mem_cmd, mem_addr);
    end
    next_cycle();
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
    @(negedge clk);
    n_tests++;
    if (if_rvalid !== 1'b1 || if_rdata !== 16'hD005 || dm_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL if_read_data: if_rvalid=%b if_rdata=%h dm_rvalid=%b, want 1 d005 0",
               if_rvalid, if_rdata, dm_rvalid);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (if_rvalid !== 1'b0 || if_rdata !== 16'hD005) begin
      n_fail++;
      $display("FAIL if_rdata_hold: if_rvalid=%b if_rdata=%h, want 0 d005", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_dm_write_read();
    next_cycle();
    drive(1'b0, 9'd0, 1'b1, 1'b1, 9'd6, 16'hABCD);
    @(negedge clk);
    n_tests++;
    if (dm_gnt !== 1'b1 || mem_cmd !== 2'b10 || mem_addr !== 9'd6 || mem_wdata !== 16'hABCD) begin
      n_fail++;
      $display("FAIL dm_write_cmd: dm_gnt=%b cmd=%b addr=%h wdata=%h, want 1 10 006 abcd",
               dm_gnt, mem_cmd, mem_addr, mem_wdata);
    end
    next_cycle();
    drive(1'b0, 9'd0, 1'b1, 1'b0, 9'd6, 16'h0);
    @(negedge clk);
    n_tests++;
    if (dm_gnt !== 1'b1 || mem_cmd !== 2'b01 || dm_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL dm_read_cmd: dm_gnt=%b cmd=%b dm_rvalid=%b, want 1 01 0",
               dm_gnt, mem_cmd, dm_rvalid);
    end
    next_cycle();
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
    @(negedge clk);
    n_tests++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== 16'hABCD) begin
      n_fail++;
      $display("FAIL dm_read_data: dm_rvalid=%b dm_rdata=%h, want 1 abcd", dm_rvalid, dm_rdata);
    end
  endtask

  task automatic test_contention();
    next_cycle();
    drive(1'b1, 9'd1, 1'b1, 1'b0, 9'd5, 16'h0);
    @(negedge clk);
    n_tests++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 9'd5) begin
      n_fail++;
      $display("FAIL contention_dm_wins: dm_gnt=%b if_gnt=%b addr=%h, want 1 0 005",
               dm_gnt, if_gnt, mem_addr);
    end
    next_cycle();
    drive(1'b1, 9'd1, 1'b0, 1'b0, 9'd0, 16'h0);
    @(negedge clk);
    n_tests++;
    if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || mem_addr !== 9'd1) begin
      n_fail++;
      $display("FAIL contention_if_next: if_gnt=%b dm_gnt=%b addr=%h, want 1 0 001",
               if_gnt, dm_gnt, mem_addr);
    end
    next_cycle();
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
    next_cycle();
  endtask

  task automatic test_fairness();
    logic exp_if;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(1'b1, 9'd2, 1'b1, 1'b0, 9'd5, 16'h0);
`ifdef MEM_ARB_FAIRNESS_EN
      exp_if = (i == 4) || (i == 9);
`else
      exp_if = 1'b0;
`endif
      @(negedge clk);
      n_tests++;
      if (if_gnt !== exp_if || dm_gnt !== !exp_if) begin
        n_fail++;
        $display("FAIL fairness_pattern[%0d]: if_gnt=%b dm_gnt=%b, want %b %b",
                 i, if_gnt, dm_gnt, exp_if, !exp_if);
      end
    end
    next_cycle();
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
    next_cycle();
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive(1'b1, 9'd1, 1'b0, 1'b0, 9'd0, 16'h0);
    @(negedge clk);
    n_tests++;
    if (if_gnt !== 1'b1 || mem_cmd !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_if1: if_gnt=%b cmd=%b, want 1 01", if_gnt, mem_cmd);
    end
    next_cycle();
    drive(1'b0, 9'd0, 1'b1, 1'b0, 9'd5, 16'h0);
    @(negedge clk);
    n_tests++;
    if (dm_gnt !== 1'b1 || mem_addr !== 9'd5 || if_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_dm5: dm_gnt=%b addr=%h if_rvalid=%b, want 1 005 1",
               dm_gnt, mem_addr, if_rvalid);
    end
    next_cycle();
    drive(1'b1, 9'd2, 1'b0, 1'b0, 9'd0, 16'h0);
    @(negedge clk);
    n_tests++;
    if (if_gnt !== 1'b1 || mem_addr !== 9'd2 || dm_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_if2: if_gnt=%b addr=%h dm_rvalid=%b, want 1 002 1",
               if_gnt, mem_addr, dm_rvalid);
    end
    next_cycle();
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    drive(1'b1, 9'd2, 1'b0, 1'b0, 9'd0, 16'h0);
    @(negedge clk);
    n_tests++;
    if (if_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_grant: if_gnt=%b, want 1", if_gnt);
    end
    next_cycle();
    reset_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    n_tests++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_cmd} !== 6'b0 ||
        if_rdata !== 16'h0 || dm_rdata !== 16'h0 || mem_addr !== 9'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: gnt=%b%b rv=%b%b cmd=%b addr=%h rdata=%h/%h, want all 0",
               if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_cmd, mem_addr, if_rdata, dm_rdata);
    end
    next_cycle();
    reset_n = 1'b1;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
    @(negedge clk);
    n_tests++;
    if (mem_cmd !== 2'b00 || if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: cmd=%b rv=%b%b, want 00 00", mem_cmd, if_rvalid, dm_rvalid);
    end
    next_cycle();
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]     = 16'(i * 16'h0101) ^ 16'h5A5A;
      exp_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    ram[0]     = 16'hD005;
    exp_mem[0] = 16'hD005;
    mem_rdata  = 16'h0;
    reset_n    = 1'b0;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);

    test_reset();
    test_if_read();
    test_dm_write_read();
    test_contention();
    test_fairness();
    test_back_to_back();
    test_reset_mid_read();

    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: %0d returns outstanding, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
